// File: rtl/trigger_sequencer_if.sv
// Sample bus, config write port and capture-control status of the trigger sequencer.
interface trigger_sequencer_if #(
  parameter int DATA_W = 16
);
  logic              sample_en;
  logic [DATA_W-1:0] data_in;
  logic              cfg_we;
  logic [3:0]        cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;
  logic              arm;
  logic              abort;
  logic              sys_run;
  logic              trig;
  logic              armed;
  logic              done;
  logic [1:0]        stage;

  modport master (
    output sample_en, data_in, cfg_we, cfg_addr, cfg_wdata, arm, abort,
    input  sys_run, trig, armed, done, stage
  );

  modport slave (
    input  sample_en, data_in, cfg_we, cfg_addr, cfg_wdata, arm, abort,
    output sys_run, trig, armed, done, stage
  );
endinterface

// File: rtl/trigger_sequencer.sv
// Four-stage value/mask/count trigger that gates the logic analyzer run enable
// and holds capture open for POST_SAMPLES qualified samples after the trigger.
module trigger_sequencer #(
  parameter int DATA_W       = 16,
  parameter int CNT_W        = 8,
  parameter int POST_SAMPLES = 64
) (
  input  logic                clk,
  input  logic                reset,
  trigger_sequencer_if.slave  bus
);
  localparam int NUM_STAGES = 4;
  localparam int PC_W = (POST_SAMPLES < 1) ? 1 : $clog2(POST_SAMPLES + 1);

  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

  state_t                             state;
  logic [NUM_STAGES-1:0][DATA_W-1:0]  value_q;
  logic [NUM_STAGES-1:0][DATA_W-1:0]  mask_q;
  logic [NUM_STAGES-1:0][CNT_W-1:0]   count_q;
  logic [1:0]                         last_q;
  logic [1:0]                         stage_q;
  logic [CNT_W-1:0]                   occ;
  logic [PC_W-1:0]                    pc;
  logic                               sys_run_q, trig_q, armed_q, done_q;

  logic [NUM_STAGES-1:0] hit;
  logic                  match;
  logic [CNT_W-1:0]      count_eff;
  logic                  occ_full;
  logic                  pc_last;

  // Every stage compares in parallel; the active stage selects its result.
  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    assign hit[s] = ((bus.data_in ^ value_q[s]) & mask_q[s]) == '0;
  end

  assign match     = bus.sample_en & hit[stage_q];
  assign count_eff = (count_q[stage_q] == '0) ? CNT_W'(1) : count_q[stage_q];
  // Widened by one bit so occ+1 cannot wrap when COUNT is all ones.
  assign occ_full  = ((CNT_W+1)'(occ) + (CNT_W+1)'(1)) >= (CNT_W+1)'(count_eff);
  assign pc_last   = ((PC_W+1)'(pc) + (PC_W+1)'(1)) == (PC_W+1)'(POST_SAMPLES);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
      mask_q  <= '0;
      count_q <= '0;
      last_q  <= '0;
    end else if (bus.cfg_we && state == IDLE) begin
      if (bus.cfg_addr == 4'hF) begin
        last_q <= bus.cfg_wdata[1:0];
      end else begin
        case (bus.cfg_addr[1:0])
          2'd0:    value_q[bus.cfg_addr[3:2]] <= bus.cfg_wdata;
          2'd1:    mask_q[bus.cfg_addr[3:2]]  <= bus.cfg_wdata;
          2'd2:    count_q[bus.cfg_addr[3:2]] <= bus.cfg_wdata[CNT_W-1:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      stage_q   <= '0;
      occ       <= '0;
      pc        <= '0;
      sys_run_q <= 1'b0;
      trig_q    <= 1'b0;
      armed_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      trig_q <= 1'b0;
      if (bus.abort) begin
        state     <= IDLE;
        stage_q   <= '0;
        occ       <= '0;
        pc        <= '0;
        sys_run_q <= 1'b0;
        armed_q   <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (bus.arm) begin
              state     <= ARMED;
              stage_q   <= '0;
              occ       <= '0;
              sys_run_q <= 1'b1;
              armed_q   <= 1'b1;
              done_q    <= 1'b0;
            end
          end
          ARMED: begin
            if (match) begin
              if (!occ_full) begin
                occ <= occ + CNT_W'(1);
              end else if (stage_q != last_q) begin
                stage_q <= stage_q + 2'd1;
                occ     <= '0;
              end else begin
                trig_q  <= 1'b1;
                occ     <= '0;
                pc      <= '0;
                armed_q <= 1'b0;
                if (POST_SAMPLES == 0) begin
                  state     <= DONE;
                  sys_run_q <= 1'b0;
                  done_q    <= 1'b1;
                end else begin
                  state <= POST;
                end
              end
            end
          end
          POST: begin
            if (bus.sample_en) begin
              if (pc_last) begin
                state     <= DONE;
                sys_run_q <= 1'b0;
                done_q    <= 1'b1;
              end else begin
                pc <= pc + PC_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.sys_run = sys_run_q;
  assign bus.trig    = trig_q;
  assign bus.armed   = armed_q;
  assign bus.done    = done_q;
  assign bus.stage   = stage_q;
endmodule
